tune_sequencer: RTL and testbench
=================================

// Module: tune_sequencer
// PURPOSE
//  Plays stored game melodies on the 50 MHz tone generator by driving its 8-bit active-low key
//  code and music enable. Sits between game logic (land, hurt, game-over events) and the tone
//  generator. Arbitrates three tune requesters by fixed priority and sequences (key, beats)
//  entries from a 64-entry ROM.
// PARAMETERS
//  BEAT_DIV    2500000  clk cycles per beat (50 ms at 50 MHz)
//  GAP_CYCLES  250000   silent cycles after every note; must be < BEAT_DIV
// PORTS
//  clk       in   1  system clock, 50 MHz
//  rst_n     in   1  reset, asynchronous, active-low
//  req       in   3  one-cycle tune requests; req[0] highest priority, req[2] lowest
//  mute      in   1  level; forces music_en=0, sequencing continues
//  key_code  out  8  to tone generator key input; 8'hff = silence
//  music_en  out  1  to tone generator enable
//  busy      out  1  high in LOAD/PLAY/GAP/DONE
//  cur_tune  out  2  index of tune being played; 2'd3 when idle
//  done      out  1  one-cycle pulse when a tune reaches its end
// BEHAVIOUR
//  Reset (async, any state): IDLE, pending=0, key_code=8'hff, music_en=0, busy=0, cur_tune=3,
//   done=0, all counters 0. Every output is registered.
//  pending[2:0]: bit k set on edge where req[k]=1; cleared on grant. A req for the tune now
//   playing is dropped.
//  Grant = lowest-index pending bit. ROM entry = {key[7:0], beats[3:0]}; tune k occupies
//   addr 16k..16k+15; beats==0 is end marker.
//  IDLE: any pending -> LOAD; addr<=16*grant; cur_tune<=grant; clear that pending bit.
//  LOAD: read ROM[addr]. beats==0 -> DONE. Otherwise -> PLAY; key_code<=key;
//   beat_cnt<=beats; cyc_cnt<=0.
//  PLAY: cyc_cnt counts 0..BEAT_DIV-1. On wrap beat_cnt decrements; at 0 -> GAP and
//   key_code<=8'hff. The note therefore lasts exactly beats*BEAT_DIV cycles.
//  GAP: GAP_CYCLES cycles of silence. If addr[3:0]==15 (region end, no marker) -> DONE;
//   else addr++ and -> LOAD.
//  DONE: one cycle; done=1, key_code=8'hff, cur_tune<=3. Then LOAD of the next grant if any
//   pending, else IDLE.
//  Preemption: in LOAD/PLAY/GAP, a pending bit of lower index than cur_tune forces LOAD of
//   that tune on the next edge. key_code is not set to 8'hff in between, and no done pulse
//   is issued for the aborted tune. The aborted tune is not re-queued. Lower-priority
//   pending bits are held until later.
//  Simultaneous req and grant of the same bit: the grant clears it and the req is lost.
//  music_en = (state==PLAY) && !mute, registered alongside key_code.
//  Latency: req at edge E0 -> LOAD at E1 -> key_code/music_en valid after E2.
//  Widths: cyc_cnt uses $clog2(BEAT_DIV) bits. beat_cnt is 4 bits. addr is 6 bits and
//   never crosses a region boundary.
// STRUCTURE
//  tune_pkg: state enum (IDLE, LOAD, PLAY, GAP, DONE), TUNE_BASE[0..2]=0/16/32,
//   END_BEATS=4'd0, KEY_SILENT=8'hff, and note key codes (NOTE_DO=8'hfe, NOTE_RE=8'hfd, ...,
//   NOTE_HDO=8'h7f ...).
//  Sub-module tune_rom: combinational case ROM, addr[5:0] -> {key, beats}.
//   Default tune0 = {fe,2},{fb,1},{ef,1},end. tune1 = {7f,1},end.
//   tune2 = {df,3},{bf,3},... 12 notes, then end.
//  The FSM and counters live in tune_sequencer.
// TESTING (BEAT_DIV=4, GAP_CYCLES=2)
//  1. Pulse req=3'b001 from IDLE -> key_code fe for 8 cycles, ff for 2, fb for 4, ff for 2,
//     ef for 4, ff for 2. Then one done pulse, busy=0, cur_tune=3.
//  2. req=3'b110 in the same cycle -> tune1 plays first (7f for 4 cycles), done pulse,
//     then tune2 starts with no IDLE cycle.
//  3. Tune2 mid-note, pulse req[0] -> next edge LOAD tune0 and key fe follows.
//     No done pulse for tune2, and tune2 does not resume.
//  4. mute=1 for the whole of tune0 -> music_en stays 0; key_code and done timing are
//     identical to test 1.
//  5. Assert rst_n=0 mid-PLAY, between edges -> key_code=ff, music_en=0, busy=0
//     immediately with no clock. After release, no replay without a new req.
//  6. ROM region with no end marker (16 notes) -> DONE after the GAP of entry 15.
//     addr never reaches the next region.

Source files
------------

// File: rtl/tune_pkg.sv
// Shared types and constants for the tune sequencer: FSM states, ROM entry layout,
// tune region bases and the active-low key codes understood by the tone generator.
package tune_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] key;
    logic [3:0] beats;
  } rom_entry_t;

  localparam logic [5:0] TUNE_BASE [0:2] = '{6'd0, 6'd16, 6'd32};
  localparam logic [3:0] END_BEATS  = 4'd0;
  localparam logic [7:0] KEY_SILENT = 8'hff;
  localparam logic [1:0] TUNE_NONE  = 2'd3;

  // One key line pulled low per note, low octave DO..SI then high DO.
  localparam logic [7:0] NOTE_DO  = 8'hfe;
  localparam logic [7:0] NOTE_RE  = 8'hfd;
  localparam logic [7:0] NOTE_MI  = 8'hfb;
  localparam logic [7:0] NOTE_FA  = 8'hf7;
  localparam logic [7:0] NOTE_SO  = 8'hef;
  localparam logic [7:0] NOTE_LA  = 8'hdf;
  localparam logic [7:0] NOTE_SI  = 8'hbf;
  localparam logic [7:0] NOTE_HDO = 8'h7f;

  function automatic logic [1:0] first_pending(input logic [2:0] p);
    if (p[0]) return 2'd0;
    if (p[1]) return 2'd1;
    if (p[2]) return 2'd2;
    return TUNE_NONE;
  endfunction

  function automatic logic [5:0] base_addr(input logic [1:0] k);
    return (k == TUNE_NONE) ? 6'd0 : TUNE_BASE[k];
  endfunction

endpackage

// File: rtl/tune_rom.sv
// Combinational melody ROM: 16 entries per tune, {key, beats}, beats==0 ends a tune.
// TUNE2_NOTES trims tune 2; at 16 the region has no end marker at all.
module tune_rom
  import tune_pkg::*;
#(
  parameter int TUNE2_NOTES = 12
) (
  input  logic [5:0] addr,
  output rom_entry_t entry
);

  localparam rom_entry_t TUNE2 [0:15] = '{
    '{NOTE_LA, 4'd3}, '{NOTE_SI, 4'd3}, '{NOTE_HDO, 4'd2}, '{NOTE_SO, 4'd1},
    '{NOTE_FA, 4'd2}, '{NOTE_MI, 4'd1}, '{NOTE_RE, 4'd2},  '{NOTE_DO, 4'd3},
    '{NOTE_MI, 4'd1}, '{NOTE_SO, 4'd2}, '{NOTE_LA, 4'd1},  '{NOTE_HDO, 4'd2},
    '{NOTE_SI, 4'd1}, '{NOTE_LA, 4'd2}, '{NOTE_SO, 4'd1},  '{NOTE_DO, 4'd4}
  };

  always_comb begin
    entry = '{key: KEY_SILENT, beats: END_BEATS};
    case (addr)
      6'd0:  entry = '{key: NOTE_DO,  beats: 4'd2};
      6'd1:  entry = '{key: NOTE_MI,  beats: 4'd1};
      6'd2:  entry = '{key: NOTE_SO,  beats: 4'd1};
      6'd16: entry = '{key: NOTE_HDO, beats: 4'd1};
      default: begin
        if (addr[5:4] == 2'd2 && int'(addr[3:0]) < TUNE2_NOTES)
          entry = TUNE2[addr[3:0]];
      end
    endcase
  end

endmodule

// File: rtl/tune_sequencer.sv
// Fixed-priority tune player: latches one-cycle requests, walks the selected ROM region
// and drives the tone generator key code and enable, with preemption by higher priority.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int BEAT_DIV    = 2500000,
  parameter int GAP_CYCLES  = 250000,
  parameter int TUNE2_NOTES = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       mute,
  output logic [7:0] key_code,
  output logic       music_en,
  output logic       busy,
  output logic [1:0] cur_tune,
  output logic       done,
  output state_t     fsm_state
);

  localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BEAT_DIV - 1);
  // The GAP state is one cycle short: the following LOAD fetch is the last silent cycle.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  state_t         state;
  logic [2:0]     pending;
  logic [5:0]     addr;
  logic [3:0]     beat_cnt;
  logic [CW-1:0]  cyc_cnt;
  logic [GW-1:0]  gap_cnt;

  rom_entry_t     entry;
  logic [1:0]     grant;
  logic [2:0]     grant_mask;
  logic [2:0]     drop_mask;
  logic [2:0]     set_mask;
  logic           any_pending;
  logic           preempt;
  logic           take;

  tune_rom #(.TUNE2_NOTES(TUNE2_NOTES)) u_rom (
    .addr  (addr),
    .entry (entry)
  );

  always_comb begin
    grant       = first_pending(pending);
    any_pending = |pending;
    grant_mask  = any_pending ? (3'b001 << grant) : 3'b000;
    drop_mask   = (cur_tune != TUNE_NONE) ? (3'b001 << cur_tune) : 3'b000;
    set_mask    = req & ~drop_mask;
    preempt     = (state inside {ST_LOAD, ST_PLAY, ST_GAP}) && (grant < cur_tune);
    take        = preempt || ((state == ST_IDLE || state == ST_DONE) && any_pending);
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pending  <= 3'b000;
      addr     <= 6'd0;
      beat_cnt <= 4'd0;
      cyc_cnt  <= '0;
      gap_cnt  <= '0;
      key_code <= KEY_SILENT;
      music_en <= 1'b0;
      busy     <= 1'b0;
      cur_tune <= TUNE_NONE;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      // A grant on the same edge as a request for that tune wins; the request is lost.
      pending <= (pending | set_mask) & ~(take ? grant_mask : 3'b000);
      if (take) begin
        state    <= ST_LOAD;
        addr     <= base_addr(grant);
        cur_tune <= grant;
        busy     <= 1'b1;
        music_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_LOAD: begin
            if (entry.beats == END_BEATS) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              key_code <= KEY_SILENT;
              cur_tune <= TUNE_NONE;
              music_en <= 1'b0;
            end else begin
              state    <= ST_PLAY;
              key_code <= entry.key;
              beat_cnt <= entry.beats;
              cyc_cnt  <= '0;
              music_en <= ~mute;
            end
          end
          ST_PLAY: begin
            music_en <= ~mute;
            if (cyc_cnt == CYC_LAST) begin
              cyc_cnt  <= '0;
              beat_cnt <= beat_cnt - 4'd1;
              if (beat_cnt == 4'd1) begin
                state    <= ST_GAP;
                key_code <= KEY_SILENT;
                music_en <= 1'b0;
                gap_cnt  <= '0;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
          ST_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              if (addr[3:0] == 4'hf) begin
                state    <= ST_DONE;
                done     <= 1'b1;
                key_code <= KEY_SILENT;
                cur_tune <= TUNE_NONE;
                music_en <= 1'b0;
              end else begin
                addr  <= addr + 6'd1;
                state <= ST_LOAD;
              end
            end else begin
              gap_cnt <= gap_cnt + GW'(1);
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
// Scoreboarded bench: each scenario's expected per-cycle output trace is derived from the
// melody lists and timing rules, queued, and checked by a negedge monitor.
module tb_tune_sequencer;
  import tune_pkg::*;

  localparam int BD  = 4;
  localparam int GAP = 2;

  typedef logic [12:0] rec_t;   // {key[7:0], music_en, done, busy, cur_tune[1:0]}
  typedef rec_t rec_q_t[$];

  localparam rec_t IDLE_REC = {8'hff, 1'b0, 1'b0, 1'b0, 2'd3};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic       mute = 1'b0;
  logic [7:0] key_code;
  logic       music_en;
  logic       busy;
  logic [1:0] cur_tune;
  logic       done;
  state_t     fsm_state;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [12:0] exp_q[$];

  tune_sequencer #(.BEAT_DIV(BD), .GAP_CYCLES(GAP), .TUNE2_NOTES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mute      (mute),
    .key_code  (key_code),
    .music_en  (music_en),
    .busy      (busy),
    .cur_tune  (cur_tune),
    .done      (done),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Melodies as {key, beats}; tune 2 is the full 16-note region without an end marker.
  int n_notes [3] = '{3, 1, 16};
  logic [11:0] notes [3][16] = '{
    '{12'hfe2, 12'hfb1, 12'hef1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
      12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000},
    '{12'h7f1, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
      12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000},
    '{12'hdf3, 12'hbf3, 12'h7f2, 12'hef1, 12'hf72, 12'hfb1, 12'hfd2, 12'hfe3,
      12'hfb1, 12'hef2, 12'hdf1, 12'h7f2, 12'hbf1, 12'hdf2, 12'hef1, 12'hfe4}
  };

  function automatic rec_t mk(logic [7:0] k, logic en, logic d, logic b, logic [1:0] t);
    return {k, en, d, b, t};
  endfunction

  // Each note: one silent fetch cycle, the note for beats*BD cycles, then GAP-1 more
  // silent cycles (fetch + these = GAP). A marker costs one more fetch; then one done cycle.
  function automatic rec_q_t tune_trace(int k, logic m);
    rec_q_t t;
    logic [11:0] e;
    logic [1:0] kt;
    kt = 2'(k);
    for (int n = 0; n < n_notes[k]; n++) begin
      e = notes[k][n];
      t.push_back(mk(8'hff, 1'b0, 1'b0, 1'b1, kt));
      for (int c = 0; c < int'(e[3:0]) * BD; c++) t.push_back(mk(e[11:4], ~m, 1'b0, 1'b1, kt));
      for (int c = 0; c < GAP - 1; c++) t.push_back(mk(8'hff, 1'b0, 1'b0, 1'b1, kt));
    end
    if (n_notes[k] < 16) t.push_back(mk(8'hff, 1'b0, 1'b0, 1'b1, kt));
    t.push_back(mk(8'hff, 1'b0, 1'b1, 1'b1, 2'd3));
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    rec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {key_code, music_en, done, busy, cur_tune};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL trace @%0d: got key=%h en=%b done=%b busy=%b tune=%0d, want key=%h en=%b done=%b busy=%b tune=%0d",
                 cyc, a[12:5], a[4], a[3], a[2], a[1:0], e[12:5], e[4], e[3], e[2], e[1:0]);
      end
    end
  end

  // r from idle at cycle 0 (again at cycle 1 if dbl); optional late request of tune
  // late_j while the first tune is at trace index q.
  task automatic run_scn(input logic [2:0] r, input logic m, input logic dbl,
                         input logic late_en, input int late_j, input int q_in);
    rec_q_t t, ft, pt;
    rec_t tmp;
    int first, q;
    logic [2:0] s;
    first = r[0] ? 0 : (r[1] ? 1 : 2);
    ft = tune_trace(first, m);
    q = (q_in > ft.size() - 3) ? ft.size() - 3 : q_in;
    t.push_back(IDLE_REC);
    t.push_back(IDLE_REC);
    if (late_en && late_j < first) begin
      for (int i = 0; i <= q + 1; i++) t.push_back(ft[i]);
      pt = tune_trace(late_j, m);
      tmp = pt[0];
      tmp[12:5] = ft[q + 1][12:5];
      pt[0] = tmp;
      foreach (pt[i]) t.push_back(pt[i]);
      s = r & ~(3'b001 << first);
    end else begin
      s = r;
      if (late_en && late_j > first) s[late_j] = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      if (s[k]) begin
        pt = tune_trace(k, m);
        foreach (pt[i]) t.push_back(pt[i]);
      end
    end
    for (int i = 0; i < 4; i++) t.push_back(IDLE_REC);
    foreach (t[i]) exp_q.push_back(t[i]);
    mute = m;
    for (int i = 0; i < t.size(); i++) begin
      req = 3'b000;
      if (i == 0 || (dbl && i == 1)) req = r;
      if (late_en && i == 2 + q) req[late_j] = 1'b1;
      tick();
    end
    req = 3'b000;
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic run_reset();
    rec_q_t t;
    t = tune_trace(0, 1'b0);
    exp_q.push_back(IDLE_REC);
    exp_q.push_back(IDLE_REC);
    foreach (t[i]) exp_q.push_back(t[i]);
    mute = 1'b0;
    req = 3'b001;
    tick();
    req = 3'b000;
    for (int i = 0; i < 7; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_key", key_code, 8'hff);
    chk("rst_en", music_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tune", cur_tune, 3);
    chk("rst_state", fsm_state, ST_IDLE);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) exp_q.push_back(IDLE_REC);
    for (int i = 0; i < 20; i++) tick();
    chk("rst_drain", exp_q.size(), 0);
  endtask

  initial begin
    tick();
    tick();
    chk("init_key", key_code, 8'hff);
    chk("init_en", music_en, 0);
    chk("init_busy", busy, 0);
    chk("init_tune", cur_tune, 3);
    chk("init_done", done, 0);
    rst_n = 1'b1;
    tick();
    run_scn(3'b001, 1'b0, 1'b0, 1'b0, 0, 0);
    run_scn(3'b110, 1'b0, 1'b0, 1'b0, 0, 0);
    run_scn(3'b100, 1'b0, 1'b0, 1'b1, 0, 5);
    run_scn(3'b001, 1'b1, 1'b0, 1'b0, 0, 0);
    run_reset();
    run_scn(3'b100, 1'b1, 1'b0, 1'b0, 0, 0);
    run_scn(3'b010, 1'b0, 1'b1, 1'b0, 0, 0);
    run_scn(3'b100, 1'b0, 1'b0, 1'b1, 2, 10);
    run_scn(3'b001, 1'b0, 1'b0, 1'b1, 2, 7);
    run_scn(3'b010, 1'b0, 1'b0, 1'b1, 0, 1);
    for (int n = 0; n < 30; n++) begin
      run_scn(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 60));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
